latency_pipe_mc: RTL
====================

Name: latency_pipe_mc

Overview:
- Multi-channel, runtime-programmable delay line for CGRA subsystem operand and predicate alignment.
- Each of NUM_CH channels delays a valid+data beat by a per-channel latency of 0..MAX_LAT cycles.
- Adds over the single-channel pipe: valid tracking, global stall, guarded latency reprogramming, and per-channel in-flight status.

Parameters:
- WIDTH, 32, data bits per channel.
- NUM_CH, 4, number of independent channels.
- MAX_LAT, 4, maximum programmable latency (>=1); stages per channel.
- RESET_LAT, 1, latency loaded into every channel on reset (0..MAX_LAT).
- LAT_W, derived, $clog2(MAX_LAT+1), latency field width (local, not overridable).
- CH_W, derived, max(1,$clog2(NUM_CH)), channel index width (local).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, synchronous, active-high.
- clr, in, 1, synchronous clear of all stage valid/data; latency config kept.
- stall, in, 1, global hold of all pipeline stages.
- cfg_we, in, 1, latency write strobe.
- cfg_ch, in, CH_W, target channel of write.
- cfg_latency, in, LAT_W, new latency value.
- cfg_err, out, 1, one-cycle pulse: previous-cycle write rejected.
- in_valid, in, NUM_CH, per-channel input valid.
- in_data, in, NUM_CH*WIDTH, channel c at bits [c*WIDTH +: WIDTH].
- out_valid, out, NUM_CH, per-channel output valid.
- out_data, out, NUM_CH*WIDTH, packed as in_data.
- ch_busy, out, NUM_CH, channel has a valid beat in its active stages.
- lat_q, out, NUM_CH*LAT_W, current latency per channel (packed).

Behaviour:
- Reset (rst=1 at posedge): all stage valid and data = 0; every lat_q = RESET_LAT; cfg_err = 0. Outputs after reset: out_valid=0, ch_busy=0; out_data=0, except latency-0 channels, which pass through.
- Per channel c with L = lat_q[c], stages s[0..MAX_LAT-1] each hold {v,d}.
- Shift (stall=0, clr=0): if L!=0, s[0] <= {in_valid[c], in_data[c]}; s[i] <= s[i-1] for 1<=i<L. Stages i>=L hold.
- stall=1: all stages hold, and in_valid beats on channels with L>0 are dropped (upstream must honour stall). out_valid/out_data continue to show s[L-1].
- clr=1 (rst=0): all stage v and d <= 0 regardless of stall; lat_q unchanged.
- Output: L==0 -> out_valid=in_valid[c], out_data=in_data[c], combinational, unaffected by stall. L>0 -> out_valid=s[L-1].v, out_data = s[L-1].v ? s[L-1].d : 0.
- Latency equals cycles from an unstalled input to the matching output; each stall cycle adds one.
- ch_busy[c] = OR of s[i].v for i<L; 0 when L==0.
- Config write on a cycle with cfg_we=1 is accepted iff:
  - cfg_latency <= MAX_LAT, and
  - ch_busy[cfg_ch]==0 or clr==1 in the same cycle, and
  - cfg_ch < NUM_CH.
- Accepted write: lat_q[cfg_ch] <= cfg_latency at that edge; new latency governs shift and output from the next cycle. Stages at or beyond the new L are not cleared: they hold stale data with v=0, because only drained channels accept writes.
- Rejected write: lat_q unchanged; cfg_err=1 for exactly the following cycle.
- Back-to-back writes are each evaluated independently.
- rst has priority over clr; clr has priority over stall.
- Stall does not block config writes.
- Expected size: ~150-250 lines of RTL.

Test Plan:
- Reset, then ch0 in_valid=1 with in_data=0xA5 for one cycle (RESET_LAT=1) -> out_valid[0]=1, out_data=0xA5 exactly one cycle later; then out_valid=0, out_data=0.
- cfg ch1 latency=3, then beats 0x11/0x22/0x33 on consecutive cycles -> out on cycles +3/+4/+5 in order; lat_q[1]=3; ch_busy[1] high from cycle +1 through +5.
- ch2 latency=0 with stall=1 -> out_data[2] follows in_data[2] combinationally. Same with ch1 latency=2: 2 stall cycles mid-flight -> beat emerges at cycle +4, with no duplicate or lost beat.
- Write ch1 latency=4 while ch_busy[1]=1 -> cfg_err pulses 1 cycle, lat_q[1] unchanged. Write cfg_latency=MAX_LAT+1 (when it fits in LAT_W) -> also rejected.
- ch3 busy with clr=1 and cfg_we (ch3, lat=2) in the same cycle -> accepted, no cfg_err, all out_valid=0 next cycle, lat_q[3]=2.
- Assert rst mid-flight on all channels -> next cycle all out_valid=0 and all lat_q=RESET_LAT; pipeline refills correctly afterwards.

Source files
------------

// File: rtl/latency_pipe_mc.sv
// Multi-channel programmable delay line.
// Each channel delays a valid+data beat by 0..MAX_LAT cycles. The design also provides:
//   - a global stall;
//   - latency writes that are accepted only on drained channels;
//   - per-channel busy status.
module latency_pipe_mc #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned MAX_LAT   = 4,
    parameter int unsigned RESET_LAT = 1,
    localparam int unsigned LAT_W    = $clog2(MAX_LAT + 1),
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    stall,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [LAT_W-1:0]        cfg_latency,
    output logic                    cfg_err,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH*LAT_W-1:0] lat_q
);

    logic             stg_v [NUM_CH][MAX_LAT];
    logic [WIDTH-1:0] stg_d [NUM_CH][MAX_LAT];
    logic [LAT_W-1:0] lat_r [NUM_CH];
    logic             tgt_busy;
    logic             cfg_ok;

    // Output tap at stage L-1 (or pass-through for L==0), busy status and packed latency view.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        ch_busy   = '0;
        lat_q     = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            lat_q[c*LAT_W +: LAT_W] = lat_r[c];
            if (lat_r[c] == '0) begin
                out_valid[c]                = in_valid[c];
                out_data[c*WIDTH +: WIDTH]  = in_data[c*WIDTH +: WIDTH];
            end else begin
                for (int i = 0; i < int'(MAX_LAT); i++) begin
                    if (i < int'(lat_r[c])) begin
                        ch_busy[c] = ch_busy[c] | stg_v[c][i];
                    end
                    // Data is masked when the tap stage holds no valid beat.
                    if ((i + 1 == int'(lat_r[c])) && stg_v[c][i]) begin
                        out_valid[c]               = 1'b1;
                        out_data[c*WIDTH +: WIDTH] = stg_d[c][i];
                    end
                end
            end
        end
    end

    // Config write acceptance: legal latency, valid channel, and target drained or being cleared.
    always_comb begin
        tgt_busy = 1'b0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (int'(cfg_ch) == c) begin
                tgt_busy = ch_busy[c];
            end
        end
        cfg_ok = cfg_we && (int'(cfg_latency) <= int'(MAX_LAT)) &&
                 (int'(cfg_ch) < int'(NUM_CH)) && (!tgt_busy || clr);
    end

    // Latency registers and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                lat_r[c] <= LAT_W'(RESET_LAT);
            end
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (cfg_ok && (int'(cfg_ch) == c)) begin
                    lat_r[c] <= cfg_latency;
                end
            end
        end
    end

    // Stage shift: only the first L stages move. Stages beyond L keep their old contents,
    // which are invalid because latency only changes on drained channels.
    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (rst || clr) begin
                for (int i = 0; i < int'(MAX_LAT); i++) begin
                    stg_v[c][i] <= 1'b0;
                    stg_d[c][i] <= '0;
                end
            end else if (!stall && (lat_r[c] != '0)) begin
                stg_v[c][0] <= in_valid[c];
                stg_d[c][0] <= in_data[c*WIDTH +: WIDTH];
                for (int i = 1; i < int'(MAX_LAT); i++) begin
                    if (i < int'(lat_r[c])) begin
                        stg_v[c][i] <= stg_v[c][i-1];
                        stg_d[c][i] <= stg_d[c][i-1];
                    end
                end
            end
        end
    end

endmodule
